sa_operand_feeder: RTL

//  Read side of the A/W operand BRAMs that the host fills. On start, loads the
//  A (MxK) and W (KxN) matrices into local buffers, then drives skewed
//  per-lane operand streams into the ARRAY_DIM x ARRAY_DIM systolic array.

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_skew_lane_sel.sv | 56 +++++
 rtl/sa_operand_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared constants, state encoding and dim helper for the systolic-array feeder.
package sa_pkg;

  localparam int   ARRAY_DIM = 8;
  localparam int   DATA_W    = 8;
  localparam int   DIM_W     = 4;
  localparam logic MODE_WS   = 1'b0;
  localparam logic MODE_OS   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PRELOAD = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Clamp a requested dimension to the physical array size.
  function automatic logic [DIM_W-1:0] sat_dim(input logic [DIM_W-1:0] d, input int lim);
    return (int'(d) > lim) ? DIM_W'(lim) : d;
  endfunction

endpackage

// File: rtl/sa_skew_lane_sel.sv
// Per-lane skew selector: maps (step, lane, dims, dataflow) to a buffer row/col and a valid.
module sa_skew_lane_sel
  import sa_pkg::*;
#(
  parameter int LANE   = 0,
  parameter bit IS_W   = 1'b0,
  parameter int STEP_W = 7
) (
  input  logic [STEP_W-1:0] step,
  input  logic              mode,
  input  logic              preload,
  input  logic              stream,
  input  logic [DIM_W-1:0]  m,
  input  logic [DIM_W-1:0]  k,
  input  logic [DIM_W-1:0]  n,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              valid
);

  logic [STEP_W-1:0] diff;
  logic              in_win;

  // diff wraps when step < LANE; in_win masks that case out.
  assign diff   = step - STEP_W'(LANE);
  assign in_win = step >= STEP_W'(LANE);

  // Skew window per side and dataflow; WS weights come out bottom row first.
  always_comb begin
    row   = '0;
    col   = '0;
    valid = 1'b0;
    if (!IS_W) begin
      if (mode == MODE_OS) begin
        row   = DIM_W'(LANE);
        col   = diff[DIM_W-1:0];
        valid = stream && (DIM_W'(LANE) < m) && in_win && (diff < STEP_W'(k));
      end else begin
        row   = diff[DIM_W-1:0];
        col   = DIM_W'(LANE);
        valid = stream && (DIM_W'(LANE) < k) && in_win && (diff < STEP_W'(m));
      end
    end else begin
      if (mode == MODE_OS) begin
        row   = diff[DIM_W-1:0];
        col   = DIM_W'(LANE);
        valid = stream && (DIM_W'(LANE) < n) && in_win && (diff < STEP_W'(k));
      end else begin
        row   = k - 1'b1 - step[DIM_W-1:0];
        col   = DIM_W'(LANE);
        valid = preload && (DIM_W'(LANE) < n);
      end
    end
  end

endmodule

// File: rtl/sa_operand_feeder.sv
// Loads A/W from BRAM into local buffers, then streams skewed operands into the PE array.
module sa_operand_feeder
  import sa_pkg::*;
#(
  parameter int ARRAY_DIM = sa_pkg::ARRAY_DIM,
  parameter int DATA_W    = sa_pkg::DATA_W,
  parameter int ADDR_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic [DIM_W-1:0]              m,
  input  logic [DIM_W-1:0]              k,
  input  logic [DIM_W-1:0]              n,
  output logic [ADDR_W-1:0]             a_addr,
  output logic                          a_en,
  input  logic [31:0]                   a_dout,
  output logic [ADDR_W-1:0]             w_addr,
  output logic                          w_en,
  input  logic [31:0]                   w_dout,
  output logic [ARRAY_DIM*DATA_W-1:0]   a_vec,
  output logic [ARRAY_DIM-1:0]          a_valid,
  output logic [ARRAY_DIM*DATA_W-1:0]   w_vec,
  output logic [ARRAY_DIM-1:0]          w_valid,
  output logic                          w_load,
  output logic                          busy,
  output logic                          done
);

  localparam int NBUF  = ARRAY_DIM * ARRAY_DIM;
  localparam int IDX_W = $clog2(NBUF);
  localparam int CNT_W = $clog2(NBUF + 1);

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   mode_q, mode_d;
  logic [DIM_W-1:0]       m_q, k_q, n_q, m_d, k_d, n_d;
  logic [CNT_W-1:0]       mk_q, kn_q, mk_d, kn_d, ld_len, st_last, cap_idx;
  logic [DATA_W-1:0]      a_buf   [NBUF];
  logic [DATA_W-1:0]      w_buf   [NBUF];
  logic [DATA_W-1:0]      a_buf_d [NBUF];
  logic [DATA_W-1:0]      w_buf_d [NBUF];
  logic                   a_en_d, w_en_d, preload_d, stream_d;
  logic [ADDR_W-1:0]      a_addr_d, w_addr_d;
  logic [ARRAY_DIM-1:0]   a_valid_d, w_valid_d;
  logic [ARRAY_DIM-1:0][DATA_W-1:0] a_lane_d, w_lane_d;
  logic                   unused_dout_hi;

  assign unused_dout_hi = ^{a_dout[31:DATA_W], w_dout[31:DATA_W]};

  assign mk_q    = CNT_W'(m_q) * CNT_W'(k_q);
  assign kn_q    = CNT_W'(k_q) * CNT_W'(n_q);
  assign mk_d    = CNT_W'(m_d) * CNT_W'(k_d);
  assign kn_d    = CNT_W'(k_d) * CNT_W'(n_d);
  assign ld_len  = (mk_q > kn_q) ? mk_q : kn_q;
  assign st_last = ((mode_q == MODE_OS) ? CNT_W'(k_q) : CNT_W'(m_q)) + CNT_W'(ARRAY_DIM - 2);

  // Next-state, counter and run-config capture; dims latched only on an accepted start.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode_q;
    m_d     = m_q;
    k_d     = k_q;
    n_d     = n_q;
    case (state)
      S_IDLE: if (start) begin
        mode_d = mode;
        m_d    = sat_dim(m, ARRAY_DIM);
        k_d    = sat_dim(k, ARRAY_DIM);
        n_d    = sat_dim(n, ARRAY_DIM);
        cnt_d  = '0;
        state_d = (m_d == '0 || k_d == '0 || n_d == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (cnt == ld_len) begin
          cnt_d   = '0;
          state_d = (mode_q == MODE_WS) ? S_PRELOAD : S_STREAM;
        end else cnt_d = cnt + 1'b1;
      end
      S_PRELOAD: begin
        if (cnt == CNT_W'(k_q) - 1'b1) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else cnt_d = cnt + 1'b1;
      end
      S_STREAM: begin
        if (cnt == st_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else cnt_d = cnt + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer view including this cycle's BRAM capture, so the first skew step can use the last word.
  always_comb begin
    a_buf_d = a_buf;
    w_buf_d = w_buf;
    cap_idx = cnt - 1'b1;
    if (state == S_LOAD && cnt != '0) begin
      if (cap_idx < mk_q) a_buf_d[cap_idx[IDX_W-1:0]] = a_dout[DATA_W-1:0];
      if (cap_idx < kn_q) w_buf_d[cap_idx[IDX_W-1:0]] = w_dout[DATA_W-1:0];
    end
  end

  // BRAM read requests for the upcoming cycle; one element per 4-byte word.
  always_comb begin
    a_en_d    = (state_d == S_LOAD) && (cnt_d < mk_d);
    w_en_d    = (state_d == S_LOAD) && (cnt_d < kn_d);
    a_addr_d  = a_en_d ? (ADDR_W'(cnt_d) << 2) : '0;
    w_addr_d  = w_en_d ? (ADDR_W'(cnt_d) << 2) : '0;
    preload_d = (state_d == S_PRELOAD);
    stream_d  = (state_d == S_STREAM);
  end

  for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
    logic [DIM_W-1:0] ar, ac, wr, wc;
    logic             av, wv;
    logic [IDX_W-1:0] ai, wi;

    sa_skew_lane_sel #(.LANE(g), .IS_W(1'b0), .STEP_W(CNT_W)) u_a_sel (
      .step(cnt_d), .mode(mode_d), .preload(preload_d), .stream(stream_d),
      .m(m_d), .k(k_d), .n(n_d), .row(ar), .col(ac), .valid(av)
    );
    sa_skew_lane_sel #(.LANE(g), .IS_W(1'b1), .STEP_W(CNT_W)) u_w_sel (
      .step(cnt_d), .mode(mode_d), .preload(preload_d), .stream(stream_d),
      .m(m_d), .k(k_d), .n(n_d), .row(wr), .col(wc), .valid(wv)
    );

    // A is row-major with stride K, W with stride N.
    assign ai           = IDX_W'(ar) * IDX_W'(k_d) + IDX_W'(ac);
    assign wi           = IDX_W'(wr) * IDX_W'(n_d) + IDX_W'(wc);
    assign a_valid_d[g] = av;
    assign w_valid_d[g] = wv;
    assign a_lane_d[g]  = av ? a_buf_d[ai] : '0;
    assign w_lane_d[g]  = wv ? w_buf_d[wi] : '0;
  end

  // Operand buffers carry no reset; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    a_buf <= a_buf_d;
    w_buf <= w_buf_d;
  end

  // State, run config and all registered outputs; reset abandons any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mode_q  <= MODE_WS;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      a_en    <= 1'b0;
      w_en    <= 1'b0;
      a_addr  <= '0;
      w_addr  <= '0;
      a_vec   <= '0;
      w_vec   <= '0;
      a_valid <= '0;
      w_valid <= '0;
      w_load  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      mode_q  <= mode_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      a_en    <= a_en_d;
      w_en    <= w_en_d;
      a_addr  <= a_addr_d;
      w_addr  <= w_addr_d;
      a_vec   <= a_lane_d;
      w_vec   <= w_lane_d;
      a_valid <= a_valid_d;
      w_valid <= w_valid_d;
      w_load  <= preload_d;
      busy    <= (state_d == S_LOAD) || preload_d || stream_d;
      done    <= (state_d == S_DONE);
    end
  end

endmodule
